// File: rtl/scoreboard_pkg.sv
// Shared types and segment codes for the scoreboard display path.
// Segment vectors are {g,f,e,d,c,b,a}, active low.
package scoreboard_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DEAD = 2'd1,
        ON   = 2'd2
    } disp_state_t;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to active-low 7-segment decoder; non-BCD codes show a dash.
module bcd_to_7seg
    import scoreboard_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg_c
);

    always_comb begin
        seg_c = SEG_DASH;
        case (bcd)
            4'd0:    seg_c = SEG_0;
            4'd1:    seg_c = SEG_1;
            4'd2:    seg_c = SEG_2;
            4'd3:    seg_c = SEG_3;
            4'd4:    seg_c = SEG_4;
            4'd5:    seg_c = SEG_5;
            4'd6:    seg_c = SEG_6;
            4'd7:    seg_c = SEG_7;
            4'd8:    seg_c = SEG_8;
            4'd9:    seg_c = SEG_9;
            default: seg_c = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/scoreboard_display.sv
// Time-multiplexed common-anode 7-segment driver for the scoreboard's packed BCD score.
// Per-frame snapshot keeps frames tear-free; dead slots between digits suppress ghosting.
module scoreboard_display
    import scoreboard_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned REFRESH_CNT  = 50000,
    parameter int unsigned DEAD_CYCLES  = 4,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    lzb_en,
    input  logic                    blink_en,
    input  logic                    display_en,
    output logic [NUM_DIGITS-1:0]   an_out,
    output logic [6:0]              seg_out,
    output logic                    dp_out,
    output logic                    frame_tick
);

    localparam int unsigned DIGITS_W = 4 * NUM_DIGITS;
    localparam int unsigned IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned CNT_MAX  = (REFRESH_CNT > DEAD_CYCLES) ? REFRESH_CNT : DEAD_CYCLES;
    localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);
    localparam int unsigned BLINK_W  = $clog2(BLINK_FRAMES + 1);

    localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0]   DEAD_LAST  = CNT_W'(DEAD_CYCLES - 1);
    localparam logic [CNT_W-1:0]   ON_LAST    = CNT_W'(REFRESH_CNT - 1);
    localparam logic [BLINK_W-1:0] BLINK_WRAP = BLINK_W'(BLINK_FRAMES);

    disp_state_t            state;
    disp_state_t            stateNext;
    logic [IDX_W-1:0]       idx;
    logic [IDX_W-1:0]       idxNext;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cntNext;
    logic                   frameStart;

    logic [DIGITS_W-1:0]    digitSnap;
    logic [NUM_DIGITS-1:0]  dpSnap;
    logic                   lzbSnap;
    logic [BLINK_W-1:0]     blinkCnt;
    logic                   blinkPhase;

    logic [NUM_DIGITS-1:0]  leadZero;
    logic [3:0]             selDigit;
    logic [6:0]             decSeg;
    logic [NUM_DIGITS-1:0]  anNext;
    logic [6:0]             segNext;
    logic                   dpNext;

    // Scan state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            idx   <= '0;
            cnt   <= '0;
        end else begin
            state <= stateNext;
            idx   <= idxNext;
            cnt   <= cntNext;
        end
    end

    // Next-state: dead slot, lit slot, advance digit; frame starts on entry to digit 0's dead slot
    always_comb begin
        stateNext  = state;
        idxNext    = idx;
        cntNext    = cnt;
        frameStart = 1'b0;
        if (!display_en) begin
            stateNext = IDLE;
            idxNext   = '0;
            cntNext   = '0;
        end else begin
            case (state)
                IDLE: begin
                    stateNext  = DEAD;
                    idxNext    = '0;
                    cntNext    = '0;
                    frameStart = 1'b1;
                end
                DEAD: begin
                    if (cnt == DEAD_LAST) begin
                        stateNext = ON;
                        cntNext   = '0;
                    end else begin
                        cntNext = cnt + CNT_W'(1);
                    end
                end
                ON: begin
                    if (cnt == ON_LAST) begin
                        stateNext = DEAD;
                        cntNext   = '0;
                        if (idx == LAST_IDX) begin
                            idxNext    = '0;
                            frameStart = 1'b1;
                        end else begin
                            idxNext = idx + IDX_W'(1);
                        end
                    end else begin
                        cntNext = cnt + CNT_W'(1);
                    end
                end
                default: stateNext = IDLE;
            endcase
        end
    end

    // leadZero[i]: snapshot digits from the top down to i are all zero
    always_comb begin
        leadZero = '0;
        leadZero[NUM_DIGITS-1] = (digitSnap[DIGITS_W-1 -: 4] == 4'd0);
        for (int i = int'(NUM_DIGITS) - 2; i >= 0; i--) begin
            leadZero[i] = leadZero[i+1] && (digitSnap[4*i +: 4] == 4'd0);
        end
    end

    assign selDigit = digitSnap[{idxNext, 2'b00} +: 4];

    bcd_to_7seg uDecode (
        .bcd   (selDigit),
        .seg_c (decSeg)
    );

    // Output values for the upcoming cycle, so outputs react on the same edge as the state
    always_comb begin
        anNext  = '1;
        segNext = SEG_BLANK;
        dpNext  = 1'b1;
        if (stateNext == ON) begin
            if (!(blink_en && blinkPhase)) begin
                anNext = ~(NUM_DIGITS'(1) << idxNext);
            end
            segNext = (lzbSnap && leadZero[idxNext] && (idxNext != '0)) ? SEG_BLANK : decSeg;
            dpNext  = ~dpSnap[idxNext];
        end
    end

    // Snapshot, blink phase and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            digitSnap  <= '0;
            dpSnap     <= '0;
            lzbSnap    <= 1'b0;
            blinkCnt   <= '0;
            blinkPhase <= 1'b0;
            an_out     <= '1;
            seg_out    <= SEG_BLANK;
            dp_out     <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            if (frameStart) begin
                digitSnap <= digits_in;
                dpSnap    <= dp_in;
                lzbSnap   <= lzb_en;
            end
            // Counter holds frames seen in the current half-period; toggle on the first frame past it
            if (!blink_en) begin
                blinkCnt   <= '0;
                blinkPhase <= 1'b0;
            end else if (frameStart) begin
                if (blinkCnt == BLINK_WRAP) begin
                    blinkCnt   <= BLINK_W'(1);
                    blinkPhase <= ~blinkPhase;
                end else begin
                    blinkCnt <= blinkCnt + BLINK_W'(1);
                end
            end
            an_out     <= anNext;
            seg_out    <= segNext;
            dp_out     <= dpNext;
            frame_tick <= frameStart;
        end
    end

endmodule

// File: tb/tb_scoreboard_display.sv
// Bench for scoreboard_display: frame-position reference model plus directed scenarios.
module tb_scoreboard_display;

    localparam int unsigned NUM   = 4;
    localparam int unsigned REF   = 8;
    localparam int unsigned DEADC = 2;
    localparam int unsigned BF    = 2;
    localparam int          SLOT  = int'(DEADC + REF);
    localparam int          FRAME = int'(NUM) * SLOT;

    logic        clk        = 1'b0;
    logic        reset_n    = 1'b1;
    logic [15:0] digits_in  = '0;
    logic [3:0]  dp_in      = '0;
    logic        lzb_en     = 1'b0;
    logic        blink_en   = 1'b0;
    logic        display_en = 1'b0;
    logic [3:0]  an_out;
    logic [6:0]  seg_out;
    logic        dp_out;
    logic        frame_tick;

    int checks = 0;
    int errors = 0;

    scoreboard_display #(
        .NUM_DIGITS   (NUM),
        .REFRESH_CNT  (REF),
        .DEAD_CYCLES  (DEADC),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .digits_in  (digits_in),
        .dp_in      (dp_in),
        .lzb_en     (lzb_en),
        .blink_en   (blink_en),
        .display_en (display_en),
        .an_out     (an_out),
        .seg_out    (seg_out),
        .dp_out     (dp_out),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    // Reference model: position within the frame, frame snapshot and frames since blink enabled
    logic        mActive = 1'b0;
    int          mT = 0;
    logic        mTick = 1'b0;
    logic [15:0] mDig = '0;
    logic [3:0]  mDp = '0;
    logic        mLzb = 1'b0;
    logic        mBlinkEn = 1'b0;
    int          mBlinkTicks = 0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mActive <= 1'b0; mT <= 0; mTick <= 1'b0; mDig <= '0; mDp <= '0;
            mLzb <= 1'b0; mBlinkEn <= 1'b0; mBlinkTicks <= 0;
        end else begin
            mBlinkEn <= blink_en;
            if (!display_en) begin
                mActive <= 1'b0;
                mTick   <= 1'b0;
                if (!blink_en) mBlinkTicks <= 0;
            end else if (!mActive || mT == FRAME - 1) begin
                mActive <= 1'b1; mT <= 0; mTick <= 1'b1;
                mDig <= digits_in; mDp <= dp_in; mLzb <= lzb_en;
                mBlinkTicks <= blink_en ? mBlinkTicks + 1 : 0;
            end else begin
                mT    <= mT + 1;
                mTick <= 1'b0;
                if (!blink_en) mBlinkTicks <= 0;
            end
        end
    end

    function automatic logic [6:0] refSeg(input logic [3:0] v);
        case (v)
            4'd0: return 7'h40;  4'd1: return 7'h79;  4'd2: return 7'h24;  4'd3: return 7'h30;
            4'd4: return 7'h19;  4'd5: return 7'h12;  4'd6: return 7'h02;  4'd7: return 7'h78;
            4'd8: return 7'h00;  4'd9: return 7'h10;
            default: return 7'h3F;
        endcase
    endfunction

    function automatic logic [11:0] expOut();
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       phase;
        int         d;
        int         p;
        an = 4'hF; seg = 7'h7F; dp = 1'b1;
        if (mActive) begin
            d = mT / SLOT;
            p = mT % SLOT;
            phase = (mBlinkTicks > 0) && ((((mBlinkTicks - 1) / int'(BF)) % 2) == 1);
            if (p >= int'(DEADC)) begin
                if (!(mBlinkEn && phase)) an[d] = 1'b0;
                seg = (mLzb && d > 0 && (mDig >> (4 * d)) == 16'h0) ? 7'h7F : refSeg(4'(mDig >> (4 * d)));
                dp = ~mDp[d];
            end
        end
        return {an, seg, dp};
    endfunction

    function automatic logic [12:0] got();
        return {an_out, seg_out, dp_out, frame_tick};
    endfunction

    function automatic logic [12:0] want();
        return {expOut(), mTick};
    endfunction

    task automatic syncFrame(output bit ok);
        int n;
        n = 0;
        @(negedge clk);
        while (frame_tick !== 1'b1 && n < 4 * FRAME) begin
            @(negedge clk);
            n++;
        end
        ok = (frame_tick === 1'b1);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; display_en = 1'b1; digits_in = 16'h1234; dp_in = 4'h0;
        lzb_en = 1'b0; blink_en = 1'b0;
        #1;
        checks++;
        if (got() !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            errors++; $display("FAIL reset_state got=%h want=%h", got(), {4'hF, 7'h7F, 1'b1, 1'b0});
        end
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (frame_tick !== 1'b1) begin
            errors++; $display("FAIL reset_first_tick got=%b want=1", frame_tick);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (an_out !== 4'hE) begin
            errors++; $display("FAIL reset_pre_lit got an=%b want 1110", an_out);
        end
        #2; reset_n = 1'b0; #1;
        checks++;
        if (got() !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            errors++; $display("FAIL reset_async got=%h want=%h", got(), {4'hF, 7'h7F, 1'b1, 1'b0});
        end
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (frame_tick !== 1'b1) begin
            errors++; $display("FAIL reset_release_tick got=%b want=1", frame_tick);
        end
    endtask

    task automatic test_scan();
        logic [3:0] anTab [4];
        logic [6:0] segTab [4];
        int         lit [4];
        bit         ok;
        anTab = '{4'hE, 4'hD, 4'hB, 4'h7};
        segTab = '{7'h19, 7'h30, 7'h24, 7'h79};
        lit = '{0, 0, 0, 0};
        digits_in = 16'h1234; dp_in = 4'h0; lzb_en = 1'b0; blink_en = 1'b0; display_en = 1'b1;
        syncFrame(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL scan_sync got no frame_tick want one within %0d cycles", 4 * FRAME); end
        for (int k = 0; k < 2 * FRAME; k++) begin
            if (k > 0) @(negedge clk);
            checks++;
            if (got() !== want()) begin errors++; $display("FAIL scan_model k=%0d got=%h want=%h", k, got(), want()); end
            if (k < FRAME) for (int d = 0; d < 4; d++) if (an_out === anTab[d]) lit[d]++;
            if (k < FRAME && (k % SLOT) == 5) begin
                checks++;
                if ({an_out, seg_out} !== {anTab[k / SLOT], segTab[k / SLOT]}) begin
                    errors++; $display("FAIL scan_slot k=%0d got an=%b seg=%h want an=%b seg=%h",
                                       k, an_out, seg_out, anTab[k / SLOT], segTab[k / SLOT]);
                end
            end
            if (k == FRAME) begin
                checks++;
                if (frame_tick !== 1'b1) begin errors++; $display("FAIL scan_period got tick=%b at 40 want 1", frame_tick); end
            end
        end
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (lit[d] != int'(REF)) begin errors++; $display("FAIL scan_lit digit%0d got %0d cycles want %0d", d, lit[d], REF); end
        end
    endtask

    task automatic test_tear_blank();
        logic [6:0] segTab [8];
        logic [3:0] anWant;
        bit         ok;
        segTab = '{7'h12, 7'h7F, 7'h7F, 7'h7F, 7'h40, 7'h40, 7'h79, 7'h7F};
        digits_in = 16'h0005; dp_in = 4'h0; lzb_en = 1'b1;
        syncFrame(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL tear_sync got no frame_tick"); end
        for (int k = 0; k < 2 * FRAME; k++) begin
            if (k > 0) @(negedge clk);
            checks++;
            if (got() !== want()) begin errors++; $display("FAIL tear_model k=%0d got=%h want=%h", k, got(), want()); end
            if ((k % SLOT) == 5) begin
                anWant = ~(4'b0001 << ((k / SLOT) % 4));
                checks++;
                if ({an_out, seg_out} !== {anWant, segTab[k / SLOT]}) begin
                    errors++; $display("FAIL tear_slot k=%0d got an=%b seg=%h want an=%b seg=%h",
                                       k, an_out, seg_out, anWant, segTab[k / SLOT]);
                end
            end
            if (k == 12) digits_in = 16'h0100;
        end
    endtask

    task automatic test_invalid_dp();
        logic dpWant;
        bit   ok;
        digits_in = 16'h00A0; dp_in = 4'b0010; lzb_en = 1'b0;
        syncFrame(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL dp_sync got no frame_tick"); end
        for (int k = 0; k < FRAME; k++) begin
            if (k > 0) @(negedge clk);
            checks++;
            if (got() !== want()) begin errors++; $display("FAIL dp_model k=%0d got=%h want=%h", k, got(), want()); end
            dpWant = ((k / SLOT) == 1 && (k % SLOT) >= int'(DEADC)) ? 1'b0 : 1'b1;
            checks++;
            if (dp_out !== dpWant) begin errors++; $display("FAIL dp_slot k=%0d got dp=%b want %b", k, dp_out, dpWant); end
            if (k == 15) begin
                checks++;
                if (seg_out !== 7'h3F) begin errors++; $display("FAIL dash_code got seg=%h want 3f", seg_out); end
            end
        end
    endtask

    task automatic test_blink();
        logic [3:0] anWant;
        bit         ok;
        digits_in = 16'h1234; dp_in = 4'h0; lzb_en = 1'b0; blink_en = 1'b1;
        syncFrame(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL blink_sync got no frame_tick"); end
        for (int k = 0; k < 6 * FRAME; k++) begin
            if (k > 0) @(negedge clk);
            checks++;
            if (got() !== want()) begin errors++; $display("FAIL blink_model k=%0d got=%h want=%h", k, got(), want()); end
            if ((k % FRAME) == 15) begin
                anWant = ((k / FRAME) == 2 || (k / FRAME) == 3) ? 4'hF : 4'hD;
                checks++;
                if (an_out !== anWant) begin
                    errors++; $display("FAIL blink_frame%0d got an=%b want %b", k / FRAME, an_out, anWant);
                end
            end
            if ((k % FRAME) == 0) begin
                checks++;
                if (frame_tick !== 1'b1) begin errors++; $display("FAIL blink_tick k=%0d got %b want 1", k, frame_tick); end
            end
        end
        blink_en = 1'b0;
    endtask

    task automatic test_disable();
        bit ok;
        digits_in = 16'h4321; dp_in = 4'h0;
        syncFrame(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL dis_sync got no frame_tick"); end
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            checks++;
            if (got() !== want()) begin errors++; $display("FAIL dis_model k=%0d got=%h want=%h", k, got(), want()); end
        end
        checks++;
        if (an_out !== 4'hB) begin errors++; $display("FAIL dis_pre got an=%b want 1011", an_out); end
        display_en = 1'b0;
        @(negedge clk);
        checks++;
        if (got() !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            errors++; $display("FAIL dis_dark got=%h want=%h", got(), {4'hF, 7'h7F, 1'b1, 1'b0});
        end
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (got() !== want()) begin errors++; $display("FAIL dis_idle got=%h want=%h", got(), want()); end
        end
        display_en = 1'b1;
        @(negedge clk);
        checks++;
        if ({an_out, frame_tick} !== {4'hF, 1'b1}) begin
            errors++; $display("FAIL reen_tick got an=%b tick=%b want an=1111 tick=1", an_out, frame_tick);
        end
        @(negedge clk);
        checks++;
        if (an_out !== 4'hF) begin errors++; $display("FAIL reen_dead got an=%b want 1111", an_out); end
        @(negedge clk);
        checks++;
        if ({an_out, seg_out} !== {4'hE, 7'h79}) begin
            errors++; $display("FAIL reen_lit got an=%b seg=%h want an=1110 seg=79", an_out, seg_out);
        end
    endtask

    task automatic test_random();
        logic [15:0] d;
        for (int k = 0; k < 800; k++) begin
            @(negedge clk);
            checks++;
            if (got() !== want()) begin errors++; $display("FAIL rand_model k=%0d got=%h want=%h", k, got(), want()); end
            if ($urandom_range(0, 9) == 0) begin
                for (int i = 0; i < 4; i++) d[4*i +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
                digits_in = d;
                dp_in = 4'($urandom_range(0, 15));
                lzb_en = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 59) == 0) display_en = ~display_en;
            if ($urandom_range(0, 99) == 0) blink_en = ~blink_en;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_scan();
        test_tear_blank();
        test_invalid_dp();
        test_blink();
        test_disable();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
